mod_updown_counter: RTL and testbench



---
 rtl/counter_pkg.sv | 34 +++
 rtl/mod_updown_counter_next.sv | 68 ++++++
 rtl/mod_updown_counter.sv | 71 +++++++
 tb/tb_mod_updown_counter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Purpose : shared constants and parameter helpers for the up/down counter family.
// Latency : n/a (package, no logic).
// Backpr. : n/a.
//
// Contents:
//   CNT_UP / CNT_DN     - direction encodings for the 'up' input
//   cnt_bound()         - highest legal count value for a given modulus
//   cnt_params_legal()  - legality rule for WIDTH / MODULUS / SATURATE,
//                         evaluated at elaboration by every counter top
package counter_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Upper bound of the count range 0..MODULUS-1.
  function automatic longint cnt_bound(input longint modulus);
    return modulus - 64'sd1;
  endfunction

  // WIDTH >= 2, 2 <= MODULUS <= 2^WIDTH, SATURATE is a single flag.
  // Width is capped so 2^WIDTH stays representable in the compare.
  function automatic bit cnt_params_legal(input int width,
                                          input longint modulus,
                                          input int saturate);
    bit ok;
    ok = 1'b1;
    if (width < 2 || width > 62) ok = 1'b0;
    else if (modulus < 2) ok = 1'b0;
    else if (modulus > (64'sd1 <<< width)) ok = 1'b0;
    if (saturate != 0 && saturate != 1) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/mod_updown_counter_next.sv
// Purpose : next-state logic of the up/down counter (load, count, wrap/saturate).
// Latency : purely combinational, zero cycles.
// Backpr. : none; 'en' is the only throttle and simply freezes the count.
//
// Ports:
//   q          in   current count (always within 0..MODULUS-1)
//   up         in   direction, CNT_UP / CNT_DN
//   en         in   count enable
//   load       in   parallel load strobe, wins over en
//   din        in   load value, clamped to MODULUS-1
//   q_next     out  value for the q register
//   wrap_next  out  value for the wrap register
import counter_pkg::*;

module counter_next #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q_next,
  output logic             wrap_next
);

  localparam logic [WIDTH-1:0] QMAX = WIDTH'(cnt_bound(MODULUS));
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  // din is compared against MODULUS-1 rather than MODULUS so the compare
  // stays inside WIDTH bits even when MODULUS = 2^WIDTH.
  logic din_over;
  assign din_over = (din > QMAX);

  logic at_top;
  logic at_bot;
  assign at_top = (q == QMAX);
  assign at_bot = (q == '0);

  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (load) begin
      q_next = din_over ? QMAX : din;
    end else if (en) begin
      if (up == CNT_UP) begin
        if (!at_top) begin
          q_next = q + ONE;
        end else if (!SATURATE) begin
          // Explicit compare even for a full binary range, so the wrap
          // flag comes from the same path for every modulus.
          q_next    = '0;
          wrap_next = 1'b1;
        end
      end else begin
        if (!at_bot) begin
          q_next = q - ONE;
        end else if (!SATURATE) begin
          q_next    = QMAX;
          wrap_next = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Purpose : parametrised synchronous up/down counter with load, wrap/saturate, tc and wrap flags.
// Latency : q and wrap update one clock after the sampling edge; tc is combinational.
// Backpr. : none; en=0 holds the count, tc may drive the en of a cascaded stage.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-low reset (q <- 0, wrap <- 0)
//   en     in   count enable
//   up     in   direction, 1 = increment, 0 = decrement
//   load   in   parallel load strobe (priority over en)
//   din    in   load value, clamped to MODULUS-1
//   q      out  current count
//   tc     out  terminal count: the next enabled edge reaches/passes a bound
//   wrap   out  one-cycle pulse while q shows a wrapped value
import counter_pkg::*;

module mod_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  if (!cnt_params_legal(WIDTH, MODULUS, int'(SATURATE))) begin : g_bad_params
    $error("mod_updown_counter: illegal WIDTH/MODULUS/SATURATE combination");
  end

  localparam logic [WIDTH-1:0] QMAX = WIDTH'(cnt_bound(MODULUS));

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  counter_next #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next (
    .q         (q),
    .up        (up),
    .en        (en),
    .load      (load),
    .din       (din),
    .q_next    (q_next),
    .wrap_next (wrap_next)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
    end
  end

  // tc deliberately ignores load and reset: a cascaded stage only needs to
  // know that this stage is enabled and sitting on the bound it moves toward.
  assign tc = en & (((up == CNT_UP) & (q == QMAX)) |
                    ((up == CNT_DN) & (q == '0)));

endmodule

// File: tb/tb_mod_updown_counter.sv
module tb_mod_updown_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] din;

  logic [3:0] q0, q1, q2;
  logic       tc0, tc1, tc2;
  logic       w0, w1, w2;

  int checks = 0;
  int errors = 0;

  // Three views of the same stimulus: decade wrap, decade saturate, full binary.
  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_dec (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .din(din),
    .q(q0), .tc(tc0), .wrap(w0));
  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .din(din),
    .q(q1), .tc(tc1), .wrap(w1));
  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) dut_bin (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .din(din),
    .q(q2), .tc(tc2), .wrap(w2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int mod_of[3] = '{10, 10, 16};
  bit sat_of[3] = '{1'b0, 1'b1, 1'b0};
  int mq[3];
  bit mw[3];

  typedef struct {
    int q[3];
    bit w[3];
    bit t[3];
    string tag;
  } exp_t;

  exp_t sbq[$];

  function automatic bit model_tc(int i, bit e, bit u);
    return e && ((u && mq[i] == mod_of[i] - 1) || (!u && mq[i] == 0));
  endfunction

  // Count range 0..M-1: wrap mode works modulo M, saturate mode clamps.
  task automatic model_edge(int i, bit rst_n, bit ld, bit e, bit u, int d);
    int m;
    int nxt;
    m = mod_of[i];
    mw[i] = 1'b0;
    if (!rst_n) begin
      mq[i] = 0;
    end else if (ld) begin
      mq[i] = (d < m) ? d : m - 1;
    end else if (e) begin
      nxt = u ? mq[i] + 1 : mq[i] - 1;
      if (nxt >= m || nxt < 0) begin
        if (sat_of[i]) begin
          nxt = mq[i];
        end else begin
          nxt = (nxt + m) % m;
          mw[i] = 1'b1;
        end
      end
      mq[i] = nxt;
    end
  endtask

  // One cycle: apply inputs after the edge, queue what must be visible this
  // cycle (state from the previous edge, tc from the new inputs), then advance.
  task automatic drive(bit rst_n, bit ld, bit e, bit u, int d, string tag);
    exp_t x;
    @(posedge clk);
    #1;
    reset = rst_n;
    load  = ld;
    en    = e;
    up    = u;
    din   = 4'(d);
    for (int i = 0; i < 3; i++) begin
      x.q[i] = mq[i];
      x.w[i] = mw[i];
      x.t[i] = model_tc(i, e, u);
    end
    x.tag = tag;
    sbq.push_back(x);
    for (int i = 0; i < 3; i++) model_edge(i, rst_n, ld, e, u, d);
  endtask

  // ---------------- monitor ----------------
  task automatic chk(string name, int inst, int act, int exp, string tag);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] (%s): got %0d expected %0d at %0t",
               name, inst, tag, act, exp, $time);
    end
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        if ($isunknown({q0, q1, q2, w0, w1, w2, tc0, tc1, tc2})) begin
          checks++;
          errors++;
          $display("FAIL unknown_outputs (%s): X/Z on DUT outputs at %0t", x.tag, $time);
        end else begin
          chk("q",    0, int'(q0),  x.q[0], x.tag);
          chk("q",    1, int'(q1),  x.q[1], x.tag);
          chk("q",    2, int'(q2),  x.q[2], x.tag);
          chk("wrap", 0, int'(w0),  int'(x.w[0]), x.tag);
          chk("wrap", 1, int'(w1),  int'(x.w[1]), x.tag);
          chk("wrap", 2, int'(w2),  int'(x.w[2]), x.tag);
          chk("tc",   0, int'(tc0), int'(x.t[0]), x.tag);
          chk("tc",   1, int'(tc1), int'(x.t[1]), x.tag);
          chk("tc",   2, int'(tc2), int'(x.t[2]), x.tag);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    en    = 1'b0;
    up    = 1'b1;
    load  = 1'b0;
    din   = 4'd0;
    for (int i = 0; i < 3; i++) begin
      mq[i] = 0;
      mw[i] = 1'b0;
    end
    // Two reset edges with no expectations: outputs are unknown before them.
    repeat (2) @(posedge clk);

    // Reset state, then count up 12 times (decade: 0..9,0,1,2).
    drive(0, 0, 0, 1, 0, "reset");
    drive(0, 1, 1, 1, 7, "reset_over_load");
    for (int k = 0; k < 12; k++) drive(1, 0, 1, 1, 0, "count_up");

    // Load 2, count down 4 times (decade: 2,1,0,9,8).
    drive(1, 1, 0, 0, 2, "load2");
    for (int k = 0; k < 4; k++) drive(1, 0, 1, 0, 0, "count_down");

    // Load clamp with en high: no count; then wrap out of 9.
    drive(1, 1, 1, 1, 14, "load_clamp");
    drive(1, 0, 1, 1, 0, "after_clamp");
    drive(1, 0, 0, 1, 0, "hold");

    // Up from 7 for 5 cycles: saturate instance sticks at 9.
    drive(1, 1, 0, 1, 7, "load7");
    for (int k = 0; k < 5; k++) drive(1, 0, 1, 1, 0, "sat_up");
    drive(1, 0, 0, 1, 0, "hold");

    // Reset on the same edge as a 9->0 wrap; then reset together with load.
    drive(1, 1, 0, 1, 6, "load6");
    drive(1, 1, 0, 1, 9, "load9");
    drive(0, 0, 1, 1, 0, "reset_on_wrap");
    drive(0, 1, 0, 1, 5, "reset_with_load");
    drive(1, 0, 0, 1, 0, "hold");

    // Full binary range wrap both ways; direction flip with no idle cycle.
    drive(1, 1, 0, 1, 15, "load15");
    drive(1, 0, 1, 1, 0, "bin_up_wrap");
    drive(1, 0, 1, 0, 0, "bin_down_wrap");
    drive(1, 0, 1, 0, 0, "bin_down");
    drive(1, 0, 1, 1, 0, "flip_up");
    drive(1, 0, 0, 0, 0, "hold");

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 29) != 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0),
            $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 15)),
            "random");
    end

    // Flush: the last edge result is observed by one more idle cycle.
    drive(1, 0, 0, 1, 0, "drain");
    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
